instr_sequencer: RTL

//  Top-level control sequencer for the microcontroller. Fetches a 16-bit instruction word and decodes opcode [15:12].

---
 rtl/instr_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches instruction words, decodes the opcode, starts one execution FSM and
// waits for its done before pulsing PC_inc. Define SEQ_WATCHDOG_EN to build the WAIT-state watchdog.
module instr_sequencer #(
   parameter int NUM_FSM        = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   input  logic [15:0]        instr,
   output logic               instr_ready,
   output logic [NUM_FSM-1:0] fsm_start,
   input  logic [NUM_FSM-1:0] fsm_done,
   output logic               fsm_abort,
   output logic [11:0]        op_param,
   output logic               PC_inc,
   output logic               busy,
   output logic               halted,
   output logic               illegal,
   output logic               timeout_err
);
   localparam int IDXW = (NUM_FSM > 1) ? $clog2(NUM_FSM) : 1;

`ifdef SEQ_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_DISPATCH, S_WAIT, S_ABORT, S_ADVANCE, S_HALT
   } state_t;

   state_t          state_q, state_d;
   logic [11:0]     op_param_q, op_param_d;
   logic [3:0]      opcode_q, opcode_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            illegal_q, illegal_d;
   logic            timeout_err_q, timeout_err_d;
   logic            done_sel;
   logic            op_exec;
   logic            wd_expired;

   assign done_sel = fsm_done[idx_q];
   assign op_exec  = (opcode_q != 4'd0) && ({28'd0, opcode_q} <= 32'(NUM_FSM));

`ifdef SEQ_WATCHDOG_EN
   logic [7:0] wd_cnt_q, wd_cnt_d;
   assign wd_expired = (wd_cnt_q == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt_q <= '0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
      end
   end

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (state_q == S_DISPATCH) begin
         wd_cnt_d = '0;
      end else if (state_q == S_WAIT && !done_sel && !wd_expired) begin
         wd_cnt_d = wd_cnt_q + 8'd1;
      end
   end
`else
   assign wd_expired = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_FETCH;
         op_param_q    <= '0;
         opcode_q      <= '0;
         idx_q         <= '0;
         illegal_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_param_q    <= op_param_d;
         opcode_q      <= opcode_d;
         idx_q         <= idx_d;
         illegal_q     <= illegal_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d       = state_q;
      op_param_d    = op_param_q;
      opcode_d      = opcode_q;
      idx_d         = idx_q;
      illegal_d     = illegal_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         S_FETCH: begin
            if (instr_valid) begin
               op_param_d = instr[11:0];
               opcode_d   = instr[15:12];
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            if (opcode_q == 4'hF) begin
               state_d = S_HALT;
            end else if (opcode_q == 4'd0) begin
               state_d = S_ADVANCE;
            end else if (op_exec) begin
               idx_d   = IDXW'(opcode_q - 4'd1);
               state_d = S_DISPATCH;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_ADVANCE;
            end
         end
         S_DISPATCH: state_d = S_WAIT;
         S_WAIT: begin
            // done on the expiry cycle takes priority over the abort
            if (done_sel) begin
               state_d = S_ADVANCE;
            end else if (wd_expired) begin
               state_d = S_ABORT;
            end
         end
         S_ABORT: begin
            timeout_err_d = WD_EN;
            state_d       = S_ADVANCE;
         end
         S_ADVANCE: state_d = S_FETCH;
         S_HALT:    state_d = S_HALT;
         default:   state_d = S_FETCH;
      endcase
   end

   for (genvar gi = 0; gi < NUM_FSM; gi++) begin : g_start
      assign fsm_start[gi] = (state_q == S_DISPATCH) && (idx_q == IDXW'(gi));
   end

   // Output logic
   always_comb begin
      instr_ready = (state_q == S_FETCH);
      fsm_abort   = WD_EN && (state_q == S_ABORT);
      PC_inc      = (state_q == S_ADVANCE);
      busy        = (state_q != S_FETCH) && (state_q != S_HALT);
      halted      = (state_q == S_HALT);
      op_param    = op_param_q;
      illegal     = illegal_q;
      timeout_err = WD_EN && timeout_err_q;
   end

endmodule
